// File: rtl/bcd_decimal_keypad_player.sv
// bcd_decimal_keypad_player
// Replays a packed multi-digit BCD code as timed one-hot decimal keypad
// strobes, most significant digit first. Each digit is pressed for
// PRESS_CYCLES cycles and released for GAP_CYCLES cycles, then a one-cycle
// done pulse is issued.
//
// Optional feature macro: PLAYER_ENTER_KEY_EN
//   When defined, an `enter` output and ENTER state are added. After the last
//   digit's gap, enter is held for PRESS_CYCLES cycles, followed by one more
//   gap before done.
//
// Handshake: start is a level sampled only while idle. A start is accepted
// on the rising edge where the FSM is IDLE, start=1 and every nibble of code
// is <= 9. Otherwise (invalid nibble) error pulses for one cycle. While busy,
// start is ignored and not queued. All outputs are registered.
module bcd_decimal_keypad_player #(
    parameter int DIGITS       = 4,
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   code,
    output logic                  busy,
    output logic [9:0]            d,
    output logic                  digit_valid,
    output logic                  done,
    output logic                  error,
`ifdef PLAYER_ENTER_KEY_EN
    output logic                  enter,
`endif
    output logic [2:0]            state_dbg
);

    localparam int CMAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRESS = 3'd1,
        GAP   = 3'd2,
        DONE  = 3'd3
`ifdef PLAYER_ENTER_KEY_EN
        ,
        ENTER = 3'd4
`endif
    } state_t;

    state_t              state_q, state_nx;
    logic [CW-1:0]       cnt_q, cnt_nx;
    logic [IW-1:0]       idx_q, idx_nx;
    logic [4*DIGITS-1:0] code_q, code_nx;
    logic [9:0]          d_q, d_nx;
    logic                busy_q, busy_nx;
    logic                dv_q, dv_nx;
    logic                done_q, done_nx;
    logic                error_q, error_nx;
    logic                code_ok;
`ifdef PLAYER_ENTER_KEY_EN
    logic                enter_q, enter_nx;
    logic                ephase_q, ephase_nx;   // set once the enter press has been played
`endif

    // Decimal key n maps to bit n of the strobe.
    function automatic logic [9:0] onehot(input logic [3:0] n);
        onehot = 10'b1 << n;
    endfunction

    // Select digit k of a packed code without a variable-width index expression.
    function automatic logic [3:0] nibble(input logic [4*DIGITS-1:0] c,
                                          input logic [IW-1:0]       k);
        nibble = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == k) nibble = c[4*i +: 4];
        end
    endfunction

    // A code is playable only if every nibble is a decimal digit.
    always_comb begin
        code_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (code[4*i +: 4] > 4'd9) code_ok = 1'b0;
        end
    end

    // Next-state logic plus next values of the registered outputs.
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        idx_nx   = idx_q;
        code_nx  = code_q;
        d_nx     = 10'b0;
        error_nx = 1'b0;
`ifdef PLAYER_ENTER_KEY_EN
        ephase_nx = ephase_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (code_ok) begin
                        code_nx  = code;
                        idx_nx   = IW'(DIGITS - 1);
                        cnt_nx   = '0;
                        state_nx = PRESS;
                        d_nx     = onehot(code[4*(DIGITS-1) +: 4]);
`ifdef PLAYER_ENTER_KEY_EN
                        ephase_nx = 1'b0;
`endif
                    end else begin
                        error_nx = 1'b1;
                    end
                end
            end
            PRESS: begin
                if (cnt_q == CW'(PRESS_CYCLES - 1)) begin
                    cnt_nx   = '0;
                    state_nx = GAP;
                end else begin
                    cnt_nx = cnt_q + CW'(1);
                    d_nx   = d_q;
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_nx = '0;
                    if (idx_q == '0) begin
`ifdef PLAYER_ENTER_KEY_EN
                        state_nx = ephase_q ? DONE : ENTER;
`else
                        state_nx = DONE;
`endif
                    end else begin
                        idx_nx   = idx_q - IW'(1);
                        state_nx = PRESS;
                        d_nx     = onehot(nibble(code_q, idx_q - IW'(1)));
                    end
                end else begin
                    cnt_nx = cnt_q + CW'(1);
                end
            end
`ifdef PLAYER_ENTER_KEY_EN
            ENTER: begin
                if (cnt_q == CW'(PRESS_CYCLES - 1)) begin
                    cnt_nx    = '0;
                    ephase_nx = 1'b1;
                    state_nx  = GAP;
                end else begin
                    cnt_nx = cnt_q + CW'(1);
                end
            end
`endif
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
        dv_nx   = (state_nx == PRESS);
        done_nx = (state_nx == DONE);
`ifdef PLAYER_ENTER_KEY_EN
        enter_nx = (state_nx == ENTER);
`endif
    end

    // State and registered outputs; reset aborts playback with no pulses.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef PLAYER_ENTER_KEY_EN
            enter_q  <= 1'b0;
            ephase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            idx_q   <= idx_nx;
            code_q  <= code_nx;
            d_q     <= d_nx;
            busy_q  <= busy_nx;
            dv_q    <= dv_nx;
            done_q  <= done_nx;
            error_q <= error_nx;
`ifdef PLAYER_ENTER_KEY_EN
            enter_q  <= enter_nx;
            ephase_q <= ephase_nx;
`endif
        end
    end

    assign busy        = busy_q;
    assign d           = d_q;
    assign digit_valid = dv_q;
    assign done        = done_q;
    assign error       = error_q;
    assign state_dbg   = state_q;
`ifdef PLAYER_ENTER_KEY_EN
    assign enter       = enter_q;
`endif

endmodule

// File: tb/tb_bcd_decimal_keypad_player.sv
// Directed bench for bcd_decimal_keypad_player with default parameters
// (4 digits, 4-cycle press, 2-cycle gap). Inputs change and outputs are
// sampled on the falling edge.
module tb_bcd_decimal_keypad_player;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] code;
    logic        busy;
    logic [9:0]  d;
    logic        digit_valid;
    logic        done;
    logic        error;
    logic        enter;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {enter, d} per playback cycle.
    logic [10:0] exp_q[$];

    bcd_decimal_keypad_player dut (
        .clock       (clk),
        .reset_n     (reset_n),
        .start       (start),
        .code        (code),
        .busy        (busy),
        .d           (d),
        .digit_valid (digit_valid),
        .done        (done),
        .error       (error),
`ifdef PLAYER_ENTER_KEY_EN
        .enter       (enter),
`endif
        .state_dbg   (state_dbg)
    );

`ifndef PLAYER_ENTER_KEY_EN
    assign enter = 1'b0;
`endif

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".d"}, 32'(d), 32'd0);
        check({tag, ".dv"}, 32'(digit_valid), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
    endtask

    // Build the expected strobe sequence for a code.
    task automatic build_expected(input logic [15:0] c);
        logic [3:0] nib;
        exp_q.delete();
        for (int k = 3; k >= 0; k--) begin
            nib = c[4*k +: 4];
            for (int p = 0; p < 4; p++) exp_q.push_back({1'b0, 10'b1 << nib});
            for (int g = 0; g < 2; g++) exp_q.push_back(11'h0);
        end
`ifdef PLAYER_ENTER_KEY_EN
        for (int p = 0; p < 4; p++) exp_q.push_back(11'h400);
        for (int g = 0; g < 2; g++) exp_q.push_back(11'h0);
`endif
    endtask

    // Play one code and check every cycle through DONE and the following IDLE.
    // With inject=1, start is pulsed mid-playback and in the DONE cycle.
    task automatic play(input logic [15:0] c, input bit inject);
        logic [10:0] e;
        int total;
        build_expected(c);
        total = exp_q.size();
        @(negedge clk);
        start = 1'b1;
        code  = c;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                code  = 16'($urandom);
            end
            e = exp_q.pop_front();
            check($sformatf("%h.c%0d.d", c, i), 32'(d), 32'(e[9:0]));
            check($sformatf("%h.c%0d.dv", c, i), 32'(digit_valid), 32'(e[9:0] != 10'h0));
            check($sformatf("%h.c%0d.busy", c, i), 32'(busy), 32'd1);
            check($sformatf("%h.c%0d.done", c, i), 32'(done), 32'd0);
`ifdef PLAYER_ENTER_KEY_EN
            check($sformatf("%h.c%0d.enter", c, i), 32'(enter), 32'(e[10]));
`endif
            if (inject && i == 4) begin
                start = 1'b1;
                code  = 16'h1111;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check($sformatf("%h.done_cycle.done", c), 32'(done), 32'd1);
        check($sformatf("%h.done_cycle.busy", c), 32'(busy), 32'd1);
        check($sformatf("%h.done_cycle.d", c), 32'(d), 32'd0);
        check($sformatf("%h.done_cycle.enter", c), 32'(enter), 32'd0);
        if (inject) begin
            start = 1'b1;
            code  = 16'h1111;
        end
        @(negedge clk);
        start = 1'b0;
        check_quiet($sformatf("%h.idle_after", c));
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        code    = 16'h0;

        // reset state
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check("reset.error", 32'(error), 32'd0);
        check("reset.enter", 32'(enter), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_quiet("post_reset");

        // valid playback and all-zero digits
        play(16'h1234, 1'b0);
        play(16'h0000, 1'b0);
        play(16'h9050, 1'b0);

        // invalid digit rejected with a single error pulse
        @(negedge clk);
        start = 1'b1;
        code  = 16'h09A0;
        @(negedge clk);
        start = 1'b0;
        check("invalid.error", 32'(error), 32'd1);
        check_quiet("invalid");
        @(negedge clk);
        check("invalid.error_clear", 32'(error), 32'd0);
        check_quiet("invalid_next");
        play(16'h1234, 1'b0);

        // start while busy is ignored
        play(16'h5678, 1'b1);
        play(16'h2468, 1'b0);

        // reset during second digit's press
        @(negedge clk);
        start = 1'b1;
        code  = 16'h1234;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 7) check("midrst.pre_d", 32'(d), 32'h004);
            if (i == 8) reset_n = 1'b0;
        end
        @(negedge clk);
        reset_n = 1'b1;
        check_quiet("midrst");
        check("midrst.error", 32'(error), 32'd0);
        begin
            int seen_activity = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (done || busy || d != 10'h0) seen_activity++;
            end
            check("midrst.stays_idle", 32'(seen_activity), 32'd0);
        end
        play(16'h9876, 1'b0);

        play(16'h4321, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
